nonce_report_arbiter: RTL and testbench

- Shares one serial transmitter between NUM_SOURCES golden-nonce producers: local miners and slave receive links in a cluster hub.
- Each source gets a one-entry holding slot.
- A round-robin scheduler picks a pending slot and serializes its 32-bit nonce as 4 bytes into the async transmitter, using its start/busy handshake.
- Sits between miner/link outputs and the single upstream TxD path.

---
 rtl/nonce_report_arbiter_pkg.sv | 27 ++
 rtl/nonce_report_arbiter_rr_arbiter.sv | 31 +++
 rtl/nonce_report_arbiter.sv | 160 ++++++++++++++++
 tb/tb_nonce_report_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nonce_report_arbiter_pkg.sv
// Shared types and constants for nonce_report_arbiter; SOURCE_TAG_EN appends a source-index byte to each frame.
package nonce_report_arbiter_pkg;

  localparam int NONCE_W = 32;
`ifdef SOURCE_TAG_EN
  localparam int BYTES_PER_NONCE = 5;
`else
  localparam int BYTES_PER_NONCE = 4;
`endif
  localparam int BIDX_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2,
    WAIT = 2'd3
  } state_t;

  // Index width, never below 1 so single-source builds still have a legal vector.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/nonce_report_arbiter_rr_arbiter.sv
// Combinational round-robin pick over req_i starting at ptr_i; zero latency, no backpressure.
module nonce_report_arbiter_rr_arbiter
  import nonce_report_arbiter_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_req_o
);

  logic found;

  always_comb begin
    grant_o   = '0;
    idx_o     = '0;
    found     = 1'b0;
    any_req_o = |req_i;
    for (int k = 0; k < N; k++) begin
      if (!found && req_i[(int'(ptr_i) + k) % N]) begin
        found = 1'b1;
        grant_o[(int'(ptr_i) + k) % N] = 1'b1;
        idx_o = IW'((int'(ptr_i) + k) % N);
      end
    end
  end

endmodule

// File: rtl/nonce_report_arbiter.sv
// Per-source one-entry slots drained round-robin as LSB-first byte frames; 3 cycles valid->tx_start when idle.
// No backpressure to sources (overflow only counted in drop_count); paced by tx_busy. SOURCE_TAG_EN adds a tag byte.
module nonce_report_arbiter
  import nonce_report_arbiter_pkg::*;
#(
  parameter int NUM_SOURCES = 4,
  parameter int DROP_CNT_W  = 8
) (
  input  logic                         hash_clk,
  input  logic                         reset,
  input  logic [NUM_SOURCES-1:0]       src_valid,
  input  logic [NONCE_W*NUM_SOURCES-1:0] src_nonce,
  output logic [7:0]                   tx_data,
  output logic                         tx_start,
  input  logic                         tx_busy,
  output logic [NUM_SOURCES-1:0]       pending,
  output logic [DROP_CNT_W-1:0]        drop_count
);

  localparam int IW = clog2(NUM_SOURCES);
  localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(BYTES_PER_NONCE - 1);
  localparam logic [31:0] DROP_MAX = 32'((64'd1 << DROP_CNT_W) - 64'd1);

  state_t                                  state_q, state_d;
  logic [BIDX_W-1:0]                       idx_q, idx_d;
  logic [NONCE_W-1:0]                      shift_q, shift_d;
  logic [IW-1:0]                           ptr_q, ptr_d;
  logic [7:0]                              tx_data_q, tx_data_d;
  logic                                    tx_start_q, tx_start_d;
  logic [NUM_SOURCES-1:0]                  pend_q, pend_d;
  logic [NUM_SOURCES-1:0][NONCE_W-1:0]     slot_q, slot_d;
  logic [DROP_CNT_W-1:0]                   drop_q, drop_d;
`ifdef SOURCE_TAG_EN
  logic [IW-1:0]                           src_q, src_d;
`endif

  logic [NUM_SOURCES-1:0] grant_oh;
  logic [NUM_SOURCES-1:0] clr;
  logic [IW-1:0]          grant_idx;
  logic                   any_req;
  logic [7:0]             cur_byte;
  logic [31:0]            n_drop;
  logic [31:0]            drop_sum;

  nonce_report_arbiter_rr_arbiter #(.N(NUM_SOURCES)) u_rr (
    .req_i     (pend_q),
    .ptr_i     (ptr_q),
    .grant_o   (grant_oh),
    .idx_o     (grant_idx),
    .any_req_o (any_req)
  );

  // A slot released by this cycle's grant is free for a same-cycle capture.
  always_comb begin
    pend_d = pend_q & ~clr;
    slot_d = slot_q;
    n_drop = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (src_valid[i]) begin
        if (pend_d[i]) begin
          n_drop = n_drop + 32'd1;
        end else begin
          pend_d[i] = 1'b1;
          slot_d[i] = src_nonce[NONCE_W*i +: NONCE_W];
        end
      end
    end
    drop_sum = 32'(drop_q) + n_drop;
    drop_d   = (drop_sum > DROP_MAX) ? DROP_CNT_W'(DROP_MAX) : DROP_CNT_W'(drop_sum);
  end

  always_comb begin
    cur_byte = shift_q[{idx_q[1:0], 3'b000} +: 8];
`ifdef SOURCE_TAG_EN
    if (idx_q == 3'd4) cur_byte = {4'h0, 4'(src_q)};
`endif
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    clr        = '0;
`ifdef SOURCE_TAG_EN
    src_d      = src_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          clr     = grant_oh;
          shift_d = slot_q[grant_idx];
          ptr_d   = (grant_idx == IW'(NUM_SOURCES - 1)) ? '0 : grant_idx + IW'(1);
          idx_d   = '0;
`ifdef SOURCE_TAG_EN
          src_d   = grant_idx;
`endif
          state_d = SEND;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          tx_data_d  = cur_byte;
          tx_start_d = 1'b1;
          state_d    = HOLD;
        end
      end
      HOLD: state_d = WAIT;
      WAIT: begin
        if (!tx_busy) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      pend_q     <= '0;
      slot_q     <= '0;
      drop_q     <= '0;
`ifdef SOURCE_TAG_EN
      src_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      pend_q     <= pend_d;
      slot_q     <= slot_d;
      drop_q     <= drop_d;
`ifdef SOURCE_TAG_EN
      src_q      <= src_d;
`endif
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_start   = tx_start_q;
  assign pending    = pend_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_nonce_report_arbiter.sv
// Directed bench for nonce_report_arbiter with a frame-level scoreboard and a busy-modelling transmitter.
module tb_nonce_report_arbiter;

  localparam int NS = 4;
`ifdef SOURCE_TAG_EN
  localparam int FB = 5;
`else
  localparam int FB = 4;
`endif

  logic              hash_clk = 1'b0;
  logic              reset = 1'b1;
  logic [NS-1:0]     src_valid = '0;
  logic [32*NS-1:0]  src_nonce = '0;
  logic              tx_busy = 1'b0;
  logic [7:0]        tx_data, tx_data2;
  logic              tx_start, tx_start2;
  logic [NS-1:0]     pending, pending2;
  logic [7:0]        drop_count;
  logic [1:0]        drop_count2;

  nonce_report_arbiter #(.NUM_SOURCES(NS), .DROP_CNT_W(8)) dut (
    .hash_clk(hash_clk), .reset(reset), .src_valid(src_valid), .src_nonce(src_nonce),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .pending(pending), .drop_count(drop_count)
  );

  nonce_report_arbiter #(.NUM_SOURCES(NS), .DROP_CNT_W(2)) dut_sat (
    .hash_clk(hash_clk), .reset(reset), .src_valid(src_valid), .src_nonce(src_nonce),
    .tx_data(tx_data2), .tx_start(tx_start2), .tx_busy(tx_busy),
    .pending(pending2), .drop_count(drop_count2)
  );

  always #5 hash_clk = ~hash_clk;

  int          vectors = 0;
  int          miscompares = 0;
  bit          mpend [NS];
  logic [31:0] mval [NS];
  int          mptr = 0;
  int          mdrop = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  obs [$];
  logic [NS-1:0]    cap_v = '0;
  logic [32*NS-1:0] cap_n = '0;
  int          busy_cnt = 0;
  bit          stall = 1'b0;
  bit          prev_start = 1'b0;
  logic [7:0]  eb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    obs.delete();
    for (int i = 0; i < NS; i++) begin
      mpend[i] = 1'b0;
      mval[i]  = '0;
    end
    mptr = 0;
    mdrop = 0;
    stall = 1'b0;
    prev_start = 1'b0;
  endtask

  // Round-robin choice among pending slots, queuing the whole frame it implies.
  task automatic model_grant();
    int g;
    g = -1;
    for (int k = 0; k < NS; k++)
      if (g < 0 && mpend[(mptr + k) % NS]) g = (mptr + k) % NS;
    if (g >= 0) begin
      for (int b = 0; b < 4; b++) exp_q.push_back(mval[g][8*b +: 8]);
`ifdef SOURCE_TAG_EN
      exp_q.push_back(8'(g));
`endif
      mpend[g] = 1'b0;
      mptr = (g + 1) % NS;
    end
  endtask

  // Transmitter: busy for 10 cycles after each start, or held busy while stalled.
  always @(negedge hash_clk) begin
    if (reset) busy_cnt = 0;
    else if (tx_start) busy_cnt = 10;
    else if (busy_cnt > 0) busy_cnt--;
    tx_busy = stall || (busy_cnt != 0);
  end

  always @(posedge hash_clk) begin
    cap_v = reset ? '0 : src_valid;
    cap_n = src_nonce;
  end

  always @(negedge hash_clk) begin
    if (!reset) begin
      if (tx_start) begin
        check("tx_start_width", prev_start, 1'b0);
        if (exp_q.size() == 0) model_grant();
        if (exp_q.size() == 0) begin
          check("unexpected_start", tx_start, 1'b0);
        end else begin
          eb = exp_q.pop_front();
          check("tx_data", tx_data, eb);
          obs.push_back(tx_data);
        end
      end
      prev_start = tx_start;
      for (int i = 0; i < NS; i++) begin
        if (cap_v[i]) begin
          if (mpend[i]) mdrop = (mdrop >= 255) ? 255 : mdrop + 1;
          else begin
            mpend[i] = 1'b1;
            mval[i]  = cap_n[32*i +: 32];
          end
        end
      end
      check("drop_count", drop_count, mdrop);
      check("drop_count_w2", drop_count2, (mdrop > 3) ? 3 : mdrop);
    end else begin
      prev_start = 1'b0;
    end
  end

  task automatic apply_reset();
    @(negedge hash_clk);
    reset = 1'b1;
    src_valid = '0;
    model_reset();
    repeat (2) @(negedge hash_clk);
    reset = 1'b0;
  endtask

  task automatic pulse(input logic [NS-1:0] v, input logic [31:0] n0, input logic [31:0] n1,
                       input logic [31:0] n2, input logic [31:0] n3);
    src_valid = v;
    src_nonce = {n3, n2, n1, n0};
    @(negedge hash_clk);
    src_valid = '0;
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int c;
    c = 0;
    while (obs.size() < n && c < budget) begin
      @(negedge hash_clk);
      c++;
    end
    check("bytes_seen", obs.size() >= n, 1'b1);
  endtask

  task automatic wait_start();
    int c;
    c = 0;
    while (!tx_start && c < 50) begin
      @(negedge hash_clk);
      c++;
    end
    check("start_seen", tx_start, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int starts;
    model_reset();
    repeat (2) @(negedge hash_clk);
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_pending", pending, 4'b0000);
    check("rst_drop", drop_count, 8'd0);
    reset = 1'b0;
    @(negedge hash_clk);

    // Single nonce, idle transmitter
    pulse(4'b0100, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0);
    check("t1_pending_set", pending, 4'b0100);
    lat = 1;
    while (!tx_start && lat < 20) begin
      @(negedge hash_clk);
      lat++;
    end
    check("t1_latency", lat, 3);
    wait_bytes(FB, 200);
    repeat (20) @(negedge hash_clk);
    check("t1_b0", obs[0], 8'hEF);
    check("t1_b1", obs[1], 8'hBE);
    check("t1_b2", obs[2], 8'hAD);
    check("t1_b3", obs[3], 8'hDE);
    check("t1_pending_clr", pending, 4'b0000);
    check("t1_frame_done", exp_q.size(), 0);

    // Simultaneous sources 0, 1, 3
    apply_reset();
    pulse(4'b1011, 32'h11111111, 32'h22222222, 32'h0, 32'h44444444);
    wait_bytes(3*FB, 600);
    repeat (50) @(negedge hash_clk);
    check("t2_first", obs[0], 8'h11);
    check("t2_second", obs[FB], 8'h22);
    check("t2_third", obs[2*FB], 8'h44);
    check("t2_total", obs.size(), 3*FB);
    check("t2_pending_clr", pending, 4'b0000);

    // Fairness: source 0 re-pulses right after its grant while 3 waits
    apply_reset();
    pulse(4'b1001, 32'hA0A1A2A3, 32'h0, 32'h0, 32'hC0C1C2C3);
    wait_start();
    pulse(4'b0001, 32'hB0B1B2B3, 32'h0, 32'h0, 32'h0);
    wait_bytes(3*FB, 600);
    check("t3_first", obs[0], 8'hA3);
    check("t3_src3_before_src0", obs[FB], 8'hC3);
    check("t3_src0_again", obs[2*FB], 8'hB3);

    // Overflow while the transmitter is stalled mid-frame
    apply_reset();
    pulse(4'b0001, 32'h10203040, 32'h0, 32'h0, 32'h0);
    wait_start();
    stall = 1'b1;
    pulse(4'b0010, 32'h0, 32'h55667788, 32'h0, 32'h0);
    check("t4_pending", pending, 4'b0010);
    for (int k = 0; k < 3; k++) pulse(4'b0010, 32'h0, 32'h99990000 + k, 32'h0, 32'h0);
    check("t4_drop3", drop_count, 8'd3);
    check("t4_drop3_w2", drop_count2, 2'd3);
    for (int k = 0; k < 2; k++) pulse(4'b0010, 32'h0, 32'hEEEE0000 + k, 32'h0, 32'h0);
    check("t4_drop5", drop_count, 8'd5);
    check("t4_sat_w2", drop_count2, 2'd3);
    check("t4_pending_kept", pending, 4'b0010);
    stall = 1'b0;
    wait_bytes(2*FB, 600);
    check("t4_frame0", obs[0], 8'h40);
    check("t4_kept_lsb", obs[FB], 8'h88);
    check("t4_kept_msb", obs[FB+3], 8'h55);

    // Reset mid-frame
    apply_reset();
    pulse(4'b0010, 32'h0, 32'h44332211, 32'h0, 32'h0);
    wait_start();
    pulse(4'b1000, 32'h0, 32'h0, 32'h0, 32'hCAFE0001);
    pulse(4'b1000, 32'h0, 32'h0, 32'h0, 32'hCAFE0002);
    wait_bytes(2, 200);
    repeat (3) @(negedge hash_clk);
    check("t5_pre_data", tx_data, 8'h22);
    check("t5_pre_pending", pending, 4'b1000);
    check("t5_pre_drop", drop_count, 8'd1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("t5_rst_start", tx_start, 1'b0);
    check("t5_rst_data", tx_data, 8'h00);
    check("t5_rst_pending", pending, 4'b0000);
    check("t5_rst_drop", drop_count, 8'd0);
    @(negedge hash_clk);
    reset = 1'b0;
    starts = 0;
    repeat (40) begin
      @(negedge hash_clk);
      if (tx_start) starts++;
    end
    check("t5_no_more_bytes", starts, 0);
    pulse(4'b1001, 32'h000000F0, 32'h0, 32'h0, 32'h0000000F);
    wait_bytes(2*FB, 600);
    check("t5_ptr_zero", obs[0], 8'hF0);
    check("t5_then_src3", obs[FB], 8'h0F);

    // Frame layout for source 3
    apply_reset();
    pulse(4'b1000, 32'h0, 32'h0, 32'h0, 32'h01020304);
    wait_bytes(FB, 200);
    check("t6_b0", obs[0], 8'h04);
    check("t6_b1", obs[1], 8'h03);
    check("t6_b2", obs[2], 8'h02);
    check("t6_b3", obs[3], 8'h01);
`ifdef SOURCE_TAG_EN
    check("t6_tag", obs[4], 8'h03);
`endif
    repeat (30) @(negedge hash_clk);
    check("t6_frame_done", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
